spill_flush_ctrl: RTL

Sequencing controller placed in front of one `spill_register_flushable` (or a chain of them sharing one flush line). It gates the upstream stream, guarantees that `flush_o` is never asserted in the same cycle as a forwarded `valid_o`, and runs either a hard flush or a graceful drain with timeout fallback. It signals completion to software or control logic and counts completed operations.

---
 rtl/spill_flush_ctrl_pkg.sv | 19 +
 rtl/spill_flush_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/spill_flush_ctrl_pkg.sv
// rtl/spill_flush_ctrl_pkg.sv - state encoding and counter sizing for spill_flush_ctrl
package spill_flush_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GATE  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } flush_state_e;

   // Wide enough to hold the largest terminal count plus the post-increment value.
   function automatic int cnt_width(input int flush_cycles, input int drain_timeout);
      int max_v;
      max_v = (flush_cycles > drain_timeout) ? flush_cycles : drain_timeout;
      return $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/spill_flush_ctrl.sv
// rtl/spill_flush_ctrl.sv - gates a flushable spill register and sequences hard flush or drain
module spill_flush_ctrl
   import spill_flush_ctrl_pkg::*;
#(
   parameter int FlushCycles  = 2,
   parameter int DrainTimeout = 16,
   parameter int CntWidth     = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_req_i,
   input  logic                drain_req_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   input  logic                pipe_valid_i,
   output logic                flush_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                timeout_o,
   output logic [CntWidth-1:0] op_cnt_o
);

   localparam int CntW = cnt_width(FlushCycles, DrainTimeout);

   flush_state_e        state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [CntWidth-1:0] op_cnt_q;
   logic                timeout_q, timeout_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         if (state_q == ST_DONE) begin
            op_cnt_q <= op_cnt_q + CntWidth'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (flush_req_i) begin
               state_d   = ST_GATE;
               timeout_d = 1'b0;
            end else if (drain_req_i) begin
               state_d   = ST_DRAIN;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         ST_GATE: begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
         end
         ST_DRAIN: begin
            cnt_d = cnt_q + CntW'(1);
            // An emptied pipe wins over a coincident timeout.
            if (!pipe_valid_i) begin
               state_d = ST_DONE;
            end else if (cnt_q == CntW'(DrainTimeout - 1)) begin
               state_d   = ST_FLUSH;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(FlushCycles - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign out_valid_o = (state_q == ST_IDLE) && in_valid_i;
   assign in_ready_o  = (state_q == ST_IDLE) && out_ready_i;
   assign flush_o     = (state_q == ST_FLUSH);
   assign done_o      = (state_q == ST_DONE);
   assign busy_o      = (state_q != ST_IDLE);
   assign timeout_o   = timeout_q;
   assign op_cnt_o    = op_cnt_q;

   a_flush_valid_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(flush_o && out_valid_o));
   a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
      done_o |=> !done_o);
   a_busy_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
      busy_o == (state_q != ST_IDLE));

endmodule
